// File: rtl/marc_ctrl_pkg.sv
`default_nettype none
//============================================================================
// Module      : marc_ctrl_pkg
// Description : Shared encodings for the mARC multicycle control sequencer:
//               state codes, opcodes, pc_sel/wb_sel codes, branch condition
//               codes and PSR bit positions. The TRAP state code is always
//               reserved; it is only reachable in builds that define
//               MARC_ILLEGAL_TRAP_EN.
// Revision    : 1.0 - initial release
//============================================================================
package marc_ctrl_pkg;

    // Sequencer state encoding (also exported on state_o)
    localparam logic [2:0] c_st_rst    = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_decode = 3'd2;
    localparam logic [2:0] c_st_exec   = 3'd3;
    localparam logic [2:0] c_st_mem    = 3'd4;
    localparam logic [2:0] c_st_wb     = 3'd5;
    localparam logic [2:0] c_st_trap   = 3'd6;

    // Major opcodes (top four instruction bits)
    localparam logic [3:0] c_op_alu  = 4'b0010;
    localparam logic [3:0] c_op_mem  = 4'b0011;
    localparam logic [3:0] c_op_jb   = 4'b0100;  // sub=0 jmpl, sub=1 branch
    localparam logic [3:0] c_op_set  = 4'b0101;
    localparam logic [3:0] c_op_call = 4'b1111;

    // PC source select
    localparam logic [1:0] c_pc_inc  = 2'd0;
    localparam logic [1:0] c_pc_disp = 2'd1;
    localparam logic [1:0] c_pc_reg  = 2'd2;
    localparam logic [1:0] c_pc_trap = 2'd3;

    // Register-file write-back source select
    localparam logic [1:0] c_wb_alu = 2'd0;
    localparam logic [1:0] c_wb_mem = 2'd1;
    localparam logic [1:0] c_wb_pc  = 2'd2;
    localparam logic [1:0] c_wb_imm = 2'd3;

    // Branch condition codes; 6 and 7 are never taken
    localparam logic [2:0] c_cond_always = 3'd0;
    localparam logic [2:0] c_cond_z      = 3'd1;
    localparam logic [2:0] c_cond_nz     = 3'd2;
    localparam logic [2:0] c_cond_n      = 3'd3;
    localparam logic [2:0] c_cond_c      = 3'd4;
    localparam logic [2:0] c_cond_v      = 3'd5;

    // PSR flag bit positions
    localparam int c_psr_c = 0;
    localparam int c_psr_v = 1;
    localparam int c_psr_z = 2;
    localparam int c_psr_n = 3;

    // True for every opcode the sequencer knows how to execute
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == c_op_alu) || (op == c_op_mem) || (op == c_op_jb) ||
               (op == c_op_set) || (op == c_op_call);
    endfunction

endpackage
`default_nettype wire

// File: rtl/marc_branch_eval.sv
`default_nettype none
//============================================================================
// Module      : marc_branch_eval
// Description : Combinational branch-condition evaluator: decides whether a
//               conditional branch is taken from its 3-bit condition code
//               and the C/V/Z/N flags.
// Revision    : 1.0 - initial release
//============================================================================
module marc_branch_eval
    import marc_ctrl_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_taken
);

    // Select the flag (or constant) that the condition code names
    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            c_cond_always: o_taken = 1'b1;
            c_cond_z:      o_taken = i_flags[c_psr_z];
            c_cond_nz:     o_taken = ~i_flags[c_psr_z];
            c_cond_n:      o_taken = i_flags[c_psr_n];
            c_cond_c:      o_taken = i_flags[c_psr_c];
            c_cond_v:      o_taken = i_flags[c_psr_v];
            default:       o_taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/marc_mc_control.sv
`default_nettype none
//============================================================================
// Module      : marc_mc_control
// Description : Multicycle control sequencer for the mARC core. Walks each
//               instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
//               datapath strobes; memory accesses use a req/ready handshake
//               so wait states may be inserted.
//               Build option MARC_ILLEGAL_TRAP_EN: when defined, an illegal
//               opcode enters a one-cycle TRAP state (trap=1, PC <- trap
//               vector); when undefined, it is retired as a NOP.
// Revision    : 1.0 - initial release
//============================================================================
module marc_mc_control
    import marc_ctrl_pkg::*;
#(
    parameter int INSTR_W    = 16,
    parameter int STATUS_W   = 5,
    parameter int REG_ADDR_W = 3,
    parameter int ALU_OP_W   = 4,
    parameter int LINK_REG   = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INSTR_W-1:0]    instruction,
    input  logic [STATUS_W-1:0]   status,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  rw_mem,
    output logic                  ir_load,
    output logic                  pc_load,
    output logic [1:0]            pc_sel,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic                  psr_we,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [1:0]            wb_sel,
    output logic                  trap,
    output logic [2:0]            state_o
);

    localparam logic [REG_ADDR_W-1:0] c_link_addr = REG_ADDR_W'(LINK_REG);

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [3:0]            w_op;
    logic                  w_sub;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [2:0]            w_cond;
    logic                  w_link_op;
    logic                  w_taken;
    logic                  w_unused;

    // Instruction field decode from the IR contents
    assign w_op      = instruction[INSTR_W-1 -: 4];
    assign w_sub     = instruction[INSTR_W-5];
    assign w_rd      = instruction[INSTR_W-6 -: REG_ADDR_W];
    assign w_cond    = instruction[INSTR_W-6 -: 3];
    assign w_link_op = (w_op == c_op_call) || ((w_op == c_op_jb) && !w_sub);

    // Only some IR bits and the low four PSR bits steer the sequencer
    assign w_unused  = ^{instruction, status};

    assign state_o   = r_state;

    marc_branch_eval u_branch_eval (
        .i_cond  (w_cond),
        .i_flags (status[3:0]),
        .o_taken (w_taken)
    );

    // State register; reset wins from any state, even mid-handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_rst;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobe decode from registered state plus instruction
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        rw_mem       = 1'b0;
        ir_load      = 1'b0;
        pc_load      = 1'b0;
        pc_sel       = c_pc_inc;
        alu_op       = '0;
        psr_we       = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = c_wb_alu;
        trap         = 1'b0;
        rf_waddr     = '0;

        // Destination is valid throughout the instruction, silent in RST
        if (r_state != c_st_rst) begin
            rf_waddr = w_link_op ? c_link_addr : w_rd;
        end

        case (r_state)
            c_st_rst: begin
                w_next_state = c_st_fetch;
            end

            c_st_fetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load      = 1'b1;
                    pc_load      = 1'b1;
                    pc_sel       = c_pc_inc;
                    w_next_state = c_st_decode;
                end
            end

            c_st_decode: begin
                if (is_legal_op(w_op)) begin
                    w_next_state = c_st_exec;
                end else begin
`ifdef MARC_ILLEGAL_TRAP_EN
                    w_next_state = c_st_trap;
`else
                    w_next_state = c_st_fetch;
`endif
                end
            end

            c_st_exec: begin
                w_next_state = c_st_fetch;
                case (w_op)
                    c_op_alu: begin
                        alu_op       = instruction[ALU_OP_W-1:0];
                        psr_we       = w_sub;
                        w_next_state = c_st_wb;
                    end
                    c_op_mem: begin
                        // ALU code 0 forms the effective address
                        alu_op       = '0;
                        w_next_state = c_st_mem;
                    end
                    c_op_jb: begin
                        if (!w_sub) begin
                            pc_load      = 1'b1;
                            pc_sel       = c_pc_reg;
                            w_next_state = c_st_wb;
                        end else if (w_taken) begin
                            pc_load = 1'b1;
                            pc_sel  = c_pc_disp;
                        end
                    end
                    c_op_set: begin
                        w_next_state = c_st_wb;
                    end
                    c_op_call: begin
                        pc_load      = 1'b1;
                        pc_sel       = c_pc_disp;
                        w_next_state = c_st_wb;
                    end
                    default: begin
                        w_next_state = c_st_fetch;
                    end
                endcase
            end

            c_st_mem: begin
                mem_req = 1'b1;
                rw_mem  = w_sub;
                if (mem_ready) begin
                    w_next_state = w_sub ? c_st_fetch : c_st_wb;
                end
            end

            c_st_wb: begin
                rf_we        = 1'b1;
                w_next_state = c_st_fetch;
                case (w_op)
                    c_op_mem:  wb_sel = c_wb_mem;
                    c_op_jb:   wb_sel = c_wb_pc;
                    c_op_call: wb_sel = c_wb_pc;
                    c_op_set:  wb_sel = c_wb_imm;
                    default:   wb_sel = c_wb_alu;
                endcase
            end

`ifdef MARC_ILLEGAL_TRAP_EN
            c_st_trap: begin
                trap         = 1'b1;
                pc_load      = 1'b1;
                pc_sel       = c_pc_trap;
                w_next_state = c_st_fetch;
            end
`endif

            default: begin
                w_next_state = c_st_fetch;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_marc_mc_control.sv
`default_nettype none
//============================================================================
// Module      : tb_marc_mc_control
// Description : Self-checking bench for marc_mc_control. A table of
//               per-cycle {inputs, expected outputs} records is applied in
//               order, followed by hand-written load-with-wait-states and
//               reset-during-MEM sequences. Honours MARC_ILLEGAL_TRAP_EN.
// Revision    : 1.0 - initial release
//============================================================================
module tb_marc_mc_control;

    logic        clk;
    logic        reset;
    logic [15:0] instruction;
    logic [4:0]  status;
    logic        mem_ready;
    logic        mem_req;
    logic        rw_mem;
    logic        ir_load;
    logic        pc_load;
    logic [1:0]  pc_sel;
    logic [3:0]  alu_op;
    logic        psr_we;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [1:0]  wb_sel;
    logic        trap;
    logic [2:0]  state_o;

    // {state, mem_req, rw_mem, ir_load, pc_load, pc_sel, alu_op, psr_we,
    //  rf_we, rf_waddr, wb_sel, trap}
    logic [20:0] w_got;

    typedef struct {
        logic        rst;
        logic [15:0] ins;
        logic [4:0]  st;
        logic        rdy;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;

    marc_mc_control #(
        .INSTR_W    (16),
        .STATUS_W   (5),
        .REG_ADDR_W (3),
        .ALU_OP_W   (4),
        .LINK_REG   (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .status      (status),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .rw_mem      (rw_mem),
        .ir_load     (ir_load),
        .pc_load     (pc_load),
        .pc_sel      (pc_sel),
        .alu_op      (alu_op),
        .psr_we      (psr_we),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .wb_sel      (wb_sel),
        .trap        (trap),
        .state_o     (state_o)
    );

    assign w_got = {state_o, mem_req, rw_mem, ir_load, pc_load, pc_sel, alu_op,
                    psr_we, rf_we, rf_waddr, wb_sel, trap};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction images: op | sub | rd/cond | 0000 | alu
    localparam logic [15:0] c_i_subcc = 16'h2B06;  // ALU, sub=1, rd=3, op 6
    localparam logic [15:0] c_i_ld    = 16'h3500;  // load, rd=5
    localparam logic [15:0] c_i_st    = 16'h3A00;  // store, rd=2
    localparam logic [15:0] c_i_bz    = 16'h4900;  // branch cond=1 (Z)
    localparam logic [15:0] c_i_ba    = 16'h4800;  // branch cond=0 (always)
    localparam logic [15:0] c_i_bnz   = 16'h4A00;  // branch cond=2 (!Z)
    localparam logic [15:0] c_i_bc    = 16'h4C00;  // branch cond=4 (C)
    localparam logic [15:0] c_i_bnv   = 16'h4E00;  // branch cond=6 (never)
    localparam logic [15:0] c_i_jmpl  = 16'h4200;  // jmpl, rd field 2
    localparam logic [15:0] c_i_call  = 16'hF000;  // call
    localparam logic [15:0] c_i_sethi = 16'h5C00;  // sethi, rd=4
    localparam logic [15:0] c_i_ill   = 16'h0000;  // illegal opcode

    function automatic logic [20:0] ex(
        input logic [2:0] s, input logic mq, input logic rw, input logic il,
        input logic pl, input logic [1:0] ps, input logic [3:0] ao,
        input logic pw, input logic rfw, input logic [2:0] wa,
        input logic [1:0] wb, input logic tr);
        return {s, mq, rw, il, pl, ps, ao, pw, rfw, wa, wb, tr};
    endfunction

    // FETCH completing (mem_ready=1), DECODE, and quiet-EXEC shorthands
    function automatic logic [20:0] e_fetch(input logic [2:0] wa);
        return ex(3'd1, 1, 0, 1, 1, 2'd0, 4'd0, 0, 0, wa, 2'd0, 0);
    endfunction
    function automatic logic [20:0] e_dec(input logic [2:0] wa);
        return ex(3'd2, 0, 0, 0, 0, 2'd0, 4'd0, 0, 0, wa, 2'd0, 0);
    endfunction
    function automatic logic [20:0] e_exq(input logic [2:0] wa);
        return ex(3'd3, 0, 0, 0, 0, 2'd0, 4'd0, 0, 0, wa, 2'd0, 0);
    endfunction

    task automatic add(input logic r, input logic [15:0] ins, input logic [4:0] st,
                       input logic rdy, input logic [20:0] exp);
        vec_t v;
        v.rst = r; v.ins = ins; v.st = st; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs after the falling edge and check outputs
    task automatic cyc(input logic r, input logic [15:0] ins, input logic [4:0] st,
                       input logic rdy, input logic [20:0] exp, input string nm);
        @(negedge clk);
        reset       = r;
        instruction = ins;
        status      = st;
        mem_ready   = rdy;
        #1;
        checks++;
        if (w_got !== exp) begin
            failures++;
            $display("FAIL %s: got %b required %b (state,req,rw,irl,pcl,pcs,alu,psr,rfwe,wa,wb,trap)",
                     nm, w_got, exp);
        end
    endtask

    initial begin
        int mreq_cycles;
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        instruction = '0;
        status      = '0;
        mem_ready   = 1'b0;

        // Reset held three cycles, then released
        add(1, c_i_subcc, 5'h00, 1, 21'd0);
        add(1, c_i_subcc, 5'h00, 1, 21'd0);
        add(1, c_i_subcc, 5'h00, 1, 21'd0);
        add(0, c_i_subcc, 5'h00, 1, 21'd0);
        // subcc with zero-wait memory: 4 cycles
        add(0, c_i_subcc, 5'h00, 1, e_fetch(3'd3));
        add(0, c_i_subcc, 5'h00, 1, e_dec(3'd3));
        add(0, c_i_subcc, 5'h00, 1, ex(3'd3, 0, 0, 0, 0, 2'd0, 4'd6, 1, 0, 3'd3, 2'd0, 0));
        add(0, c_i_subcc, 5'h00, 1, ex(3'd5, 0, 0, 0, 0, 2'd0, 4'd0, 0, 1, 3'd3, 2'd0, 0));
        // store, zero wait: 4 cycles, write request, no rf_we
        add(0, c_i_st, 5'h00, 1, e_fetch(3'd2));
        add(0, c_i_st, 5'h00, 1, e_dec(3'd2));
        add(0, c_i_st, 5'h00, 1, e_exq(3'd2));
        add(0, c_i_st, 5'h00, 1, ex(3'd4, 1, 1, 0, 0, 2'd0, 4'd0, 0, 0, 3'd2, 2'd0, 0));
        // branch on Z with Z=1: taken
        add(0, c_i_bz, 5'h04, 1, e_fetch(3'd1));
        add(0, c_i_bz, 5'h04, 1, e_dec(3'd1));
        add(0, c_i_bz, 5'h04, 1, ex(3'd3, 0, 0, 0, 1, 2'd1, 4'd0, 0, 0, 3'd1, 2'd0, 0));
        // branch on Z with Z=0: not taken
        add(0, c_i_bz, 5'h00, 1, e_fetch(3'd1));
        add(0, c_i_bz, 5'h00, 1, e_dec(3'd1));
        add(0, c_i_bz, 5'h00, 1, e_exq(3'd1));
        // branch always with flags clear: taken
        add(0, c_i_ba, 5'h00, 1, e_fetch(3'd0));
        add(0, c_i_ba, 5'h00, 1, e_dec(3'd0));
        add(0, c_i_ba, 5'h00, 1, ex(3'd3, 0, 0, 0, 1, 2'd1, 4'd0, 0, 0, 3'd0, 2'd0, 0));
        // branch on !Z with Z=1: not taken
        add(0, c_i_bnz, 5'h04, 1, e_fetch(3'd2));
        add(0, c_i_bnz, 5'h04, 1, e_dec(3'd2));
        add(0, c_i_bnz, 5'h04, 1, e_exq(3'd2));
        // cond 6 never taken even with every flag set
        add(0, c_i_bnv, 5'h1F, 1, e_fetch(3'd6));
        add(0, c_i_bnv, 5'h1F, 1, e_dec(3'd6));
        add(0, c_i_bnv, 5'h1F, 1, e_exq(3'd6));
        // branch on C with C=1: taken
        add(0, c_i_bc, 5'h01, 1, e_fetch(3'd4));
        add(0, c_i_bc, 5'h01, 1, e_dec(3'd4));
        add(0, c_i_bc, 5'h01, 1, ex(3'd3, 0, 0, 0, 1, 2'd1, 4'd0, 0, 0, 3'd4, 2'd0, 0));
        // call: PC+disp in EXEC, link write of r7 in WB
        add(0, c_i_call, 5'h00, 1, e_fetch(3'd7));
        add(0, c_i_call, 5'h00, 1, e_dec(3'd7));
        add(0, c_i_call, 5'h00, 1, ex(3'd3, 0, 0, 0, 1, 2'd1, 4'd0, 0, 0, 3'd7, 2'd0, 0));
        add(0, c_i_call, 5'h00, 1, ex(3'd5, 0, 0, 0, 0, 2'd0, 4'd0, 0, 1, 3'd7, 2'd2, 0));
        // jmpl: PC from register, link write of r7
        add(0, c_i_jmpl, 5'h00, 1, e_fetch(3'd7));
        add(0, c_i_jmpl, 5'h00, 1, e_dec(3'd7));
        add(0, c_i_jmpl, 5'h00, 1, ex(3'd3, 0, 0, 0, 1, 2'd2, 4'd0, 0, 0, 3'd7, 2'd0, 0));
        add(0, c_i_jmpl, 5'h00, 1, ex(3'd5, 0, 0, 0, 0, 2'd0, 4'd0, 0, 1, 3'd7, 2'd2, 0));
        // sethi behind one fetch wait state
        add(0, c_i_sethi, 5'h00, 0, ex(3'd1, 1, 0, 0, 0, 2'd0, 4'd0, 0, 0, 3'd4, 2'd0, 0));
        add(0, c_i_sethi, 5'h00, 1, e_fetch(3'd4));
        add(0, c_i_sethi, 5'h00, 1, e_dec(3'd4));
        add(0, c_i_sethi, 5'h00, 1, e_exq(3'd4));
        add(0, c_i_sethi, 5'h00, 1, ex(3'd5, 0, 0, 0, 0, 2'd0, 4'd0, 0, 1, 3'd4, 2'd3, 0));
        // illegal opcode 0000
        add(0, c_i_ill, 5'h00, 1, e_fetch(3'd0));
        add(0, c_i_ill, 5'h00, 1, e_dec(3'd0));
`ifdef MARC_ILLEGAL_TRAP_EN
        add(0, c_i_ill, 5'h00, 0, ex(3'd6, 0, 0, 0, 1, 2'd3, 4'd0, 0, 0, 3'd0, 2'd0, 1));
`endif
        // next instruction fetch starts immediately after
        add(0, c_i_ill, 5'h00, 0, ex(3'd1, 1, 0, 0, 0, 2'd0, 4'd0, 0, 0, 3'd0, 2'd0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].ins, vecs[i].st, vecs[i].rdy, vecs[i].exp,
                $sformatf("vec%0d", i));
        end

        // Load with two memory wait states: 7 cycles, request held 3
        cyc(0, c_i_ld, 5'h00, 1, e_fetch(3'd5), "ld_fetch");
        cyc(0, c_i_ld, 5'h00, 1, e_dec(3'd5), "ld_decode");
        cyc(0, c_i_ld, 5'h00, 0, e_exq(3'd5), "ld_exec");
        mreq_cycles = 0;
        for (int w = 0; w < 3; w++) begin
            cyc(0, c_i_ld, 5'h00, (w == 2), ex(3'd4, 1, 0, 0, 0, 2'd0, 4'd0, 0, 0, 3'd5, 2'd0, 0),
                $sformatf("ld_mem%0d", w));
            if (mem_req === 1'b1) mreq_cycles++;
        end
        checks++;
        if (mreq_cycles != 3) begin
            failures++;
            $display("FAIL ld_req_len: got %0d required 3", mreq_cycles);
        end
        cyc(0, c_i_ld, 5'h00, 0, ex(3'd5, 0, 0, 0, 0, 2'd0, 4'd0, 0, 1, 3'd5, 2'd1, 0), "ld_wb");
        cyc(0, c_i_st, 5'h00, 0, ex(3'd1, 1, 0, 0, 0, 2'd0, 4'd0, 0, 0, 3'd2, 2'd0, 0), "ld_next_fetch");

        // Reset asserted mid-MEM drops the request on the next cycle
        cyc(0, c_i_st, 5'h00, 1, e_fetch(3'd2), "rs_fetch");
        cyc(0, c_i_st, 5'h00, 1, e_dec(3'd2), "rs_decode");
        cyc(0, c_i_st, 5'h00, 0, e_exq(3'd2), "rs_exec");
        cyc(0, c_i_st, 5'h00, 0, ex(3'd4, 1, 1, 0, 0, 2'd0, 4'd0, 0, 0, 3'd2, 2'd0, 0), "rs_mem_wait");
        cyc(1, c_i_st, 5'h00, 0, ex(3'd4, 1, 1, 0, 0, 2'd0, 4'd0, 0, 0, 3'd2, 2'd0, 0), "rs_mem_reset");
        cyc(1, c_i_st, 5'h00, 1, 21'd0, "rs_rst");
        cyc(0, c_i_st, 5'h00, 1, 21'd0, "rs_release");
        cyc(0, c_i_st, 5'h00, 1, e_fetch(3'd2), "rs_refetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
